// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU controller: opcode encoding and FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROTL = 4'h6,
    OP_ROTR = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; div0 flags a divide with a zero divisor.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             div0
);

  logic shift_big_s;

  assign shift_big_s = (32'(b) >= 32'(WIDTH));
  assign div0        = (op == OP_DIV) && (b == '0);

  // Opcode decode; arithmetic naturally truncates to WIDTH bits
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_DIV:  if (b == '0) result = '1; else result = a / b;
      OP_SHL:  if (shift_big_s) result = '0; else result = a << b;
      OP_SHR:  if (shift_big_s) result = '0; else result = a >> b;
      OP_ROTL: result = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROTR: result = {a[0], a[WIDTH-1:1]};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_NAND: result = ~(a & b);
      OP_XNOR: result = ~(a ^ b);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: IDLE -> EXEC -> RESP handshake FSM around alu_core.
// Define ALU_SEQ_ERR_EN to build the registered divide-by-zero flag on rsp_err.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [7:0]       op_count
);

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, b_r, data_r, alu_res_s;
  op_e              op_r;
  logic             valid_r, ready_s, alu_div0_s;
  logic [7:0]       count_r;
  logic             cmd_hs_s, rsp_hs_s;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (a_r),
    .b      (b_r),
    .op     (op_r),
    .result (alu_res_s),
    .div0   (alu_div0_s)
  );

  assign cmd_hs_s  = cmd_valid && ready_s;
  assign rsp_hs_s  = valid_r && rsp_ready;
  // Ready is held low while reset is asserted even though the state reads IDLE
  assign cmd_ready = ready_s && rst_n;
  assign rsp_valid = valid_r;
  assign rsp_data  = data_r;
  assign op_count  = count_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (cmd_valid) state_nxt_s = ST_EXEC; else state_nxt_s = ST_IDLE;
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: if (rsp_hs_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Operand capture on command handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= OP_ADD;
    end else if (cmd_hs_s) begin
      a_r  <= cmd_a;
      b_r  <= cmd_b;
      op_r <= op_e'(cmd_op);
    end
  end

  // Result capture in EXEC; div0 override keeps the data all-ones regardless of core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  data_r <= '0;
    else if (state_r == ST_EXEC) data_r <= alu_div0_s ? '1 : alu_res_s;
  end

  // Response valid rises one cycle into RESP and drops on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               valid_r <= 1'b0;
    else if ((state_r == ST_RESP) && !rsp_hs_s) valid_r <= 1'b1;
    else                                      valid_r <= 1'b0;
  end

  // Completed-response counter, wraps at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_r <= 8'd0;
    else if (rsp_hs_s) count_r <= count_r + 8'd1;
  end

`ifdef ALU_SEQ_ERR_EN
  logic err_r;

  // Divide-by-zero flag, captured alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_r <= 1'b0;
    else if (state_r == ST_EXEC) err_r <= alu_div0_s;
  end

  assign rsp_err = err_r;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with hand-computed expected values.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_op;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic exp_div_err;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction with latency, result and handshake checks
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] exp_data, input logic exp_err);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = 1'b0;
    check({tag, "_ready_idle"}, cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_ready_exec"}, cmd_ready, 0);
    check({tag, "_valid_n1"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid_n2pre"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check({tag, "_valid_done"}, rsp_valid, 0);
    check({tag, "_count"}, op_count, exp_count);
    check({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int hs;
    int cyc;
    logic pend;
`ifdef ALU_SEQ_ERR_EN
    exp_div_err = 1'b1;
`else
    exp_div_err = 1'b0;
`endif
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = 4'h0; cmd_b = 4'h0; cmd_op = 4'h0;
    #3;
    check("rst_ready", cmd_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    check("rst_count", op_count, 0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;

    do_op("add",  4'hA, 4'h1, 4'h0, 4'hB, 1'b0);
    do_op("sub",  4'h1, 4'h2, 4'h1, 4'hF, 1'b0);
    do_op("mul",  4'h5, 4'h4, 4'h2, 4'h4, 1'b0);
    do_op("div0", 4'hA, 4'h0, 4'h3, 4'hF, exp_div_err);
    do_op("div",  4'hB, 4'h3, 4'h3, 4'h3, 1'b0);
    do_op("rotl", 4'hA, 4'h7, 4'h6, 4'h5, 1'b0);
    do_op("rotr", 4'hA, 4'h7, 4'h7, 4'h5, 1'b0);
    do_op("shl4", 4'hA, 4'h4, 4'h4, 4'h0, 1'b0);
    do_op("shl1", 4'h5, 4'h1, 4'h4, 4'hA, 1'b0);
    do_op("shr",  4'hC, 4'h2, 4'h5, 4'h3, 1'b0);
    do_op("nor",  4'hA, 4'h4, 4'hB, 4'h1, 1'b0);
    do_op("gt",   4'h2, 4'h7, 4'hE, 4'h0, 1'b0);
    do_op("eq",   4'h3, 4'h3, 4'hF, 4'h1, 1'b0);

    // Stall in RESP with a second command waiting on cmd_valid
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 4'h6; cmd_b = 4'h3; cmd_op = 4'h1;
    @(posedge clk); #1;
    cmd_a = 4'h2; cmd_b = 4'h3; cmd_op = 4'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 4'h3);
      check("stall_ready", cmd_ready, 0);
      check("stall_count", op_count, exp_count);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 1;
    check("stall_count_hs", op_count, exp_count);
    check("stall_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("queued_accept", cmd_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queued_valid", rsp_valid, 1);
    check("queued_data", rsp_data, 4'h2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while a command is in EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 4'h1; cmd_b = 4'h1; cmd_op = 4'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_data", rsp_data, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    exp_count = 0;
    check("rel_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rel_no_valid", rsp_valid, 0);
    end
    check("rel_count", op_count, 0);

    // 256 back-to-back handshakes wrap the counter
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 4'h1; cmd_b = 4'h1; cmd_op = 4'h0; rsp_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 256 && cyc < 3000) begin
      @(negedge clk);
      pend = rsp_valid;
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        hs++;
        if (hs == 255) check("count_255", op_count, 255);
        if (hs == 256) cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    check("wrap_handshakes", hs, 256);
    check("wrap_count", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
